// File: rtl/sd_power_manager.sv
// Power-policy FSM for the SD power controller: power-state request, voltage selection and wake handshake.
// Defining SD_PM_AUTO_SLEEP_EN enables the IDLE -> SLEEP demotion timer; without it IDLE holds indefinitely.
module sd_power_manager #(
  parameter int CNT_W         = 16,
  parameter int IDLE_TIMEOUT  = 256,
  parameter int SLEEP_TIMEOUT = 4096,
  parameter int PG_TIMEOUT    = 1024
) (
  input  logic       PCLK_i,
  input  logic       PRESET_i,
  input  logic       sw_pwr_on_i,
  input  logic       activity_i,
  input  logic       wake_req_i,
  input  logic [3:0] voltage_req_i,
  input  logic       power_good_i,
  input  logic       power_fault_i,
  input  logic       sticky_clear_i,
  output logic [1:0] power_state_o,
  output logic [3:0] voltage_sel_o,
  output logic       wake_ack_o,
  output logic [2:0] pm_state_o,
  output logic       pg_timeout_o,
  output logic       fault_seen_o
);

  typedef enum logic [2:0] {
    ST_DOWN   = 3'd0,
    ST_WAKE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_IDLE   = 3'd3,
    ST_SLEEP  = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Each timeout fires in the cycle the timer holds TIMEOUT-1, i.e. after exactly TIMEOUT cycles in the state.
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PG_LAST    = CNT_W'(PG_TIMEOUT - 1);
`ifdef SD_PM_AUTO_SLEEP_EN
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_TIMEOUT - 1);
`endif

  localparam longint TIMER_MAX = (longint'(1) << CNT_W) - 1;

  if (IDLE_TIMEOUT < 1 || longint'(IDLE_TIMEOUT) > TIMER_MAX) begin : g_bad_idle_timeout
    $error("IDLE_TIMEOUT out of range for CNT_W");
  end
  if (SLEEP_TIMEOUT < 1 || longint'(SLEEP_TIMEOUT) > TIMER_MAX) begin : g_bad_sleep_timeout
    $error("SLEEP_TIMEOUT out of range for CNT_W");
  end
  if (PG_TIMEOUT < 1 || longint'(PG_TIMEOUT) > TIMER_MAX) begin : g_bad_pg_timeout
    $error("PG_TIMEOUT out of range for CNT_W");
  end

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nx;
  logic             wake_pending;
  logic             wake_pending_nx;
  logic             wake_ack_nx;
  logic             timer_restart;
  logic             pg_timeout_set;
  logic             fault_set;
  logic             busy;
  logic             wake_seen;

  function automatic logic [1:0] power_code(input state_t s);
    case (s)
      ST_WAKE, ST_ACTIVE: power_code = 2'b00;
      ST_IDLE:            power_code = 2'b01;
      ST_SLEEP:           power_code = 2'b10;
      default:            power_code = 2'b11;
    endcase
  endfunction

  assign busy       = activity_i | wake_req_i;
  assign wake_seen  = wake_req_i & (state inside {ST_WAKE, ST_IDLE, ST_SLEEP});
  assign pm_state_o = state;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_nx       = state;
    timer_restart  = 1'b0;
    pg_timeout_set = 1'b0;
    fault_set      = 1'b0;

    case (state)
      ST_DOWN:  if (sw_pwr_on_i) state_nx = ST_WAKE;
      ST_FAULT: if (!sw_pwr_on_i) state_nx = ST_DOWN;
      ST_WAKE, ST_ACTIVE, ST_IDLE, ST_SLEEP: begin
        if (!sw_pwr_on_i) begin
          state_nx = ST_DOWN;
        end else if (power_fault_i) begin
          state_nx  = ST_FAULT;
          fault_set = 1'b1;
        end else begin
          case (state)
            ST_WAKE: begin
              if (power_good_i) begin
                state_nx = ST_ACTIVE;
              end else if (timer == PG_LAST) begin
                state_nx       = ST_FAULT;
                pg_timeout_set = 1'b1;
              end
            end
            ST_ACTIVE: begin
              if (!power_good_i)            state_nx      = ST_WAKE;
              else if (busy)                timer_restart = 1'b1;
              else if (timer == IDLE_LAST)  state_nx      = ST_IDLE;
            end
            ST_IDLE: begin
              if (busy) state_nx = ST_ACTIVE;
`ifdef SD_PM_AUTO_SLEEP_EN
              else if (timer == SLEEP_LAST) state_nx = ST_SLEEP;
`endif
            end
            ST_SLEEP: if (busy) state_nx = ST_WAKE;
            default: ;
          endcase
        end
      end
      default: state_nx = ST_DOWN;
    endcase
  end

  always_comb begin
    timer_nx = timer;
    if (state_nx != state || timer_restart) begin
      timer_nx = '0;
    end else if ((state inside {ST_WAKE, ST_ACTIVE, ST_IDLE}) && timer != '1) begin
      timer_nx = timer + 1'b1;
    end
  end

  // Ack on entry to ACTIVE for a pending request, or directly for a request seen while already ACTIVE and powered.
  always_comb begin
    wake_ack_nx = ((state_nx == ST_ACTIVE) && (state != ST_ACTIVE) && (wake_pending || wake_seen)) ||
                  ((state == ST_ACTIVE) && (state_nx == ST_ACTIVE) && wake_req_i && power_good_i);
    if (state_nx inside {ST_DOWN, ST_FAULT, ST_ACTIVE}) wake_pending_nx = 1'b0;
    else                                                wake_pending_nx = wake_pending | wake_seen;
  end

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state         <= ST_DOWN;
      timer         <= '0;
      wake_pending  <= 1'b0;
      power_state_o <= 2'b11;
      voltage_sel_o <= 4'd0;
      wake_ack_o    <= 1'b0;
      pg_timeout_o  <= 1'b0;
      fault_seen_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
      state         <= state_nx;
      timer         <= timer_nx;
      wake_pending  <= wake_pending_nx;
      power_state_o <= power_code(state_nx);
      wake_ack_o    <= wake_ack_nx;
      pg_timeout_o  <= pg_timeout_set | (pg_timeout_o & ~sticky_clear_i);
      fault_seen_o  <= fault_set | (fault_seen_o & ~sticky_clear_i);
      if (state == ST_DOWN) voltage_sel_o <= voltage_req_i;
    end
  end

endmodule

// File: tb/tb_sd_power_manager.sv
// Self-checking bench for sd_power_manager: directed scenarios plus randomized traffic against a behavioural model.
// Expectations follow SD_PM_AUTO_SLEEP_EN the same way the design does.
module tb_sd_power_manager;

  localparam int IDLE_TO  = 8;
  localparam int SLEEP_TO = 16;
  localparam int PG_TO    = 32;
`ifdef SD_PM_AUTO_SLEEP_EN
  localparam bit AUTO_SLEEP = 1'b1;
`else
  localparam bit AUTO_SLEEP = 1'b0;
`endif

  logic       PCLK_i = 1'b0;
  logic       PRESET_i;
  logic       sw_pwr_on_i;
  logic       activity_i;
  logic       wake_req_i;
  logic [3:0] voltage_req_i;
  logic       power_good_i;
  logic       power_fault_i;
  logic       sticky_clear_i;
  logic [1:0] power_state_o;
  logic [3:0] voltage_sel_o;
  logic       wake_ack_o;
  logic [2:0] pm_state_o;
  logic       pg_timeout_o;
  logic       fault_seen_o;

  int n_checks = 0;
  int n_fail   = 0;

  wire [11:0] snap = {pm_state_o, power_state_o, voltage_sel_o, wake_ack_o, pg_timeout_o, fault_seen_o};
  logic [11:0] exp;

  sd_power_manager #(
    .CNT_W        (16),
    .IDLE_TIMEOUT (IDLE_TO),
    .SLEEP_TIMEOUT(SLEEP_TO),
    .PG_TIMEOUT   (PG_TO)
  ) dut (
    .PCLK_i        (PCLK_i),
    .PRESET_i      (PRESET_i),
    .sw_pwr_on_i   (sw_pwr_on_i),
    .activity_i    (activity_i),
    .wake_req_i    (wake_req_i),
    .voltage_req_i (voltage_req_i),
    .power_good_i  (power_good_i),
    .power_fault_i (power_fault_i),
    .sticky_clear_i(sticky_clear_i),
    .power_state_o (power_state_o),
    .voltage_sel_o (voltage_sel_o),
    .wake_ack_o    (wake_ack_o),
    .pm_state_o    (pm_state_o),
    .pg_timeout_o  (pg_timeout_o),
    .fault_seen_o  (fault_seen_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge PCLK_i);
      #1;
    end
  endtask

  // Expected output snapshot: state code 0 DOWN,1 WAKE,2 ACTIVE,3 IDLE,4 SLEEP,5 FAULT with its power request.
  function automatic logic [11:0] pack(input int st, input logic [3:0] v, input bit ack, input bit pgto, input bit flt);
    logic [1:0] ps;
    case (st)
      1, 2:    ps = 2'b00;
      3:       ps = 2'b01;
      4:       ps = 2'b10;
      default: ps = 2'b11;
    endcase
    return {3'(st), ps, v, ack, pgto, flt};
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_DOWN, M_WAKE, M_ACTIVE, M_IDLE, M_SLEEP, M_FAULT} mst_t;
  mst_t       m_state = M_DOWN;
  int         m_age   = 0;   // whole cycles already spent in the current state
  logic [3:0] m_volt  = 4'd0;
  bit         m_ack, m_pend, m_pgto, m_flt;

  task automatic model_step;
    mst_t ns;
    bit   restart, req_seen, set_pg, set_flt, busy, ack;
    int   this_cycle;
    if (PRESET_i) begin
      m_state = M_DOWN; m_age = 0; m_volt = 4'd0;
      m_ack = 0; m_pend = 0; m_pgto = 0; m_flt = 0;
      return;
    end
    ns = m_state; restart = 0; set_pg = 0; set_flt = 0;
    busy       = activity_i || wake_req_i;
    req_seen   = wake_req_i && (m_state == M_WAKE || m_state == M_IDLE || m_state == M_SLEEP);
    this_cycle = m_age + 1;
    if (m_state == M_DOWN) begin
      if (sw_pwr_on_i) ns = M_WAKE;
    end else if (m_state == M_FAULT) begin
      if (!sw_pwr_on_i) ns = M_DOWN;
    end else if (!sw_pwr_on_i) begin
      ns = M_DOWN;
    end else if (power_fault_i) begin
      ns = M_FAULT; set_flt = 1;
    end else if (m_state == M_WAKE) begin
      if (power_good_i) ns = M_ACTIVE;
      else if (this_cycle == PG_TO) begin ns = M_FAULT; set_pg = 1; end
    end else if (m_state == M_ACTIVE) begin
      if (!power_good_i) ns = M_WAKE;
      else if (busy) restart = 1;
      else if (this_cycle == IDLE_TO) ns = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (busy) ns = M_ACTIVE;
      else if (AUTO_SLEEP && this_cycle == SLEEP_TO) ns = M_SLEEP;
    end else begin
      if (busy) ns = M_WAKE;
    end
    ack = (ns == M_ACTIVE && m_state != M_ACTIVE && (m_pend || req_seen)) ||
          (ns == M_ACTIVE && m_state == M_ACTIVE && wake_req_i && power_good_i);
    if (m_state == M_DOWN) m_volt = voltage_req_i;
    m_ack  = ack;
    m_pend = (ns == M_DOWN || ns == M_FAULT || ns == M_ACTIVE) ? 1'b0 : (m_pend || req_seen);
    m_age  = (ns != m_state || restart) ? 0 : this_cycle;
    m_pgto = set_pg  || (m_pgto && !sticky_clear_i);
    m_flt  = set_flt || (m_flt && !sticky_clear_i);
    m_state = ns;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset;
    PRESET_i = 1; tick(2);
    n_checks++; exp = pack(0, 4'd0, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL reset_values: got %h want %h", snap, exp); end
    PRESET_i = 0; tick();
    n_checks++; exp = pack(0, 4'd0, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL reset_down_hold: got %h want %h", snap, exp); end
  endtask

  task automatic test_power_up;
    voltage_req_i = 4'd3; sw_pwr_on_i = 1; tick();
    n_checks++; exp = pack(1, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pwrup_wake: got %h want %h", snap, exp); end
    voltage_req_i = 4'd9; tick(4);
    n_checks++; exp = pack(1, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pwrup_voltage_frozen: got %h want %h", snap, exp); end
    power_good_i = 1; tick();
    n_checks++; exp = pack(2, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pwrup_active: got %h want %h", snap, exp); end
  endtask

  task automatic test_demotion;
    int bad;
    tick(7);
    n_checks++; exp = pack(2, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_active_7: got %h want %h", snap, exp); end
    tick();
    n_checks++; exp = pack(3, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_idle_8: got %h want %h", snap, exp); end
    activity_i = 1; tick(); activity_i = 0;
    n_checks++; exp = pack(2, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_activity_return: got %h want %h", snap, exp); end
    tick(8);
    n_checks++; exp = pack(3, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_idle_again: got %h want %h", snap, exp); end
`ifdef SD_PM_AUTO_SLEEP_EN
    tick(SLEEP_TO - 1);
    n_checks++; exp = pack(3, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_idle_15: got %h want %h", snap, exp); end
    tick();
    n_checks++; exp = pack(4, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL demote_sleep: got %h want %h", snap, exp); end
`else
    bad = 0;
    repeat (1000) begin
      tick();
      if (pm_state_o !== 3'd3 || power_state_o !== 2'b01) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle_persists: got %0d bad cycles want 0", bad); end
`endif
  endtask

  task automatic test_wake;
`ifdef SD_PM_AUTO_SLEEP_EN
    power_good_i = 0; wake_req_i = 1; tick(); wake_req_i = 0;
    n_checks++; exp = pack(1, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL sleep_wake_state: got %h want %h", snap, exp); end
    tick(2); power_good_i = 1; tick();
    n_checks++; exp = pack(2, 4'd3, 1, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL sleep_wake_ack: got %h want %h", snap, exp); end
`else
    wake_req_i = 1; tick(); wake_req_i = 0;
    n_checks++; exp = pack(2, 4'd3, 1, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL idle_wake_ack: got %h want %h", snap, exp); end
`endif
    tick();
    n_checks++; exp = pack(2, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL wake_ack_one_cycle: got %h want %h", snap, exp); end
    wake_req_i = 1; tick(); wake_req_i = 0;
    n_checks++; exp = pack(2, 4'd3, 1, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL active_wake_ack: got %h want %h", snap, exp); end
    power_good_i = 0; tick();
    n_checks++; exp = pack(1, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pg_loss_to_wake: got %h want %h", snap, exp); end
    wake_req_i = 1; tick(); wake_req_i = 0; tick();
    power_good_i = 1; tick();
    n_checks++; exp = pack(2, 4'd3, 1, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL wake_pending_ack: got %h want %h", snap, exp); end
    tick();
    n_checks++; exp = pack(2, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL wake_pending_cleared: got %h want %h", snap, exp); end
  endtask

  task automatic test_pg_timeout;
    power_good_i = 0; tick(); tick(PG_TO - 1);
    n_checks++; exp = pack(1, 4'd3, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pgto_wake_31: got %h want %h", snap, exp); end
    tick();
    n_checks++; exp = pack(5, 4'd3, 0, 1, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pgto_fault: got %h want %h", snap, exp); end
    sw_pwr_on_i = 0; tick();
    n_checks++; exp = pack(0, 4'd3, 0, 1, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pgto_down_sticky: got %h want %h", snap, exp); end
    sticky_clear_i = 1; tick(); sticky_clear_i = 0;
    n_checks++; exp = pack(0, 4'd9, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pgto_clear: got %h want %h", snap, exp); end
  endtask

  task automatic test_priority;
    wake_req_i = 1; tick(); wake_req_i = 0;
    sw_pwr_on_i = 1; power_good_i = 0; tick(); tick(PG_TO - 1);
    power_good_i = 1; tick();
    n_checks++; exp = pack(2, 4'd9, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL pg_beats_timeout_no_ack: got %h want %h", snap, exp); end
    tick(IDLE_TO - 1); activity_i = 1; tick(); activity_i = 0;
    n_checks++; exp = pack(2, 4'd9, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL activity_beats_timeout: got %h want %h", snap, exp); end
    tick(IDLE_TO - 1);
    n_checks++; exp = pack(2, 4'd9, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL timer_restarted: got %h want %h", snap, exp); end
    tick();
    power_fault_i = 1; activity_i = 1; tick(); power_fault_i = 0; activity_i = 0;
    n_checks++; exp = pack(5, 4'd9, 0, 0, 1);
    if (snap !== exp) begin n_fail++; $display("FAIL idle_fault_beats_activity: got %h want %h", snap, exp); end
    sticky_clear_i = 1; tick(); sticky_clear_i = 0;
    sw_pwr_on_i = 0; tick(); sw_pwr_on_i = 1; tick();
    power_fault_i = 1; sticky_clear_i = 1; tick(); power_fault_i = 0; sticky_clear_i = 0;
    n_checks++; exp = pack(5, 4'd9, 0, 0, 1);
    if (snap !== exp) begin n_fail++; $display("FAIL set_beats_clear: got %h want %h", snap, exp); end
    sw_pwr_on_i = 0; tick();
  endtask

  task automatic test_reset_mid;
    voltage_req_i = 4'd5; tick();
    sw_pwr_on_i = 1; power_good_i = 0; tick(3);
    n_checks++; exp = pack(1, 4'd5, 0, 0, 1);
    if (snap !== exp) begin n_fail++; $display("FAIL midreset_in_wake: got %h want %h", snap, exp); end
    PRESET_i = 1; tick(); PRESET_i = 0;
    n_checks++; exp = pack(0, 4'd0, 0, 0, 0);
    if (snap !== exp) begin n_fail++; $display("FAIL midreset_values: got %h want %h", snap, exp); end
    sw_pwr_on_i = 0; tick();
  endtask

  task automatic test_random;
    bit quiet = 0;
    int shown = 0;
    PRESET_i = 1; model_step(); tick(); PRESET_i = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) quiet = ($urandom_range(0, 2) == 0);
      PRESET_i       = ($urandom_range(0, 999) == 0);
      sw_pwr_on_i    = quiet ? ($urandom_range(0, 999) != 0) : ($urandom_range(0, 99) < 97);
      power_fault_i  = ($urandom_range(0, 199) == 0);
      power_good_i   = quiet ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 9) != 0);
      activity_i     = quiet ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) < 2);
      wake_req_i     = quiet ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0);
      sticky_clear_i = ($urandom_range(0, 49) == 0);
      voltage_req_i  = 4'($urandom);
      model_step();
      tick();
      exp = pack(int'(m_state), m_volt, m_ack, m_pgto, m_flt);
      n_checks++;
      if (snap !== exp) begin
        n_fail++;
        if (shown < 20) $display("FAIL random_cycle_%0d: got %h want %h", c, snap, exp);
        shown++;
      end
    end
    PRESET_i = 0; sw_pwr_on_i = 0; power_fault_i = 0; activity_i = 0;
    wake_req_i = 0; sticky_clear_i = 0;
  endtask

  initial begin
    PRESET_i = 1; sw_pwr_on_i = 0; activity_i = 0; wake_req_i = 0;
    voltage_req_i = 4'd0; power_good_i = 0; power_fault_i = 0; sticky_clear_i = 0;
    test_reset();
    test_power_up();
    test_demotion();
    test_wake();
    test_pg_timeout();
    test_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
